mpr121_i2c_target: RTL and testbench

Synthesizable I2C target (responder) that emulates an MPR121-style byte-addressed register file on the open-drain SCL/SDA pad signals. It is the far end of the sensor core's I2C master. It sits in the bench/bring-up build behind a bidirectional pad pair, or directly on the master's SCL_OUT/SDA_OUT/EN nets, so the I2C controller can be exercised without the external chip. A host port lets the core or testbench preload register contents (touch status, filtered data) and observe bus writes.

---
 rtl/mpr121_i2c_target.sv | 190 +++++++++++++++++++
 tb/tb_mpr121_i2c_target.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mpr121_i2c_target.sv
// rtl/mpr121_i2c_target.sv - I2C target emulating an MPR121-style byte-addressed register file
// SCL/SDA are oversampled on i_CLK; every bus-facing output comes straight from a flop.
module mpr121_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h5A,
  parameter int         REG_AW   = 7
) (
  input  logic              i_CLK,
  input  logic              i_RST,
  input  logic              i_SCL_IN,
  input  logic              i_SDA_IN,
  output logic              o_SDA_OUT,
  output logic              o_SDA_EN,
  output logic              o_SCL_EN,
  input  logic              i_host_we,
  input  logic [REG_AW-1:0] i_host_addr,
  input  logic [7:0]        i_host_wdata,
  output logic              o_wr_valid,
  output logic [REG_AW-1:0] o_wr_addr,
  output logic [7:0]        o_wr_data,
  output logic              o_busy
);
  localparam int NREG = 1 << REG_AW;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK
  } state_e;

  state_e            state_q;
  logic [2:0]        scl_sync_q;
  logic [2:0]        sda_sync_q;
  logic [2:0]        bit_cnt_q;
  logic [7:0]        shift_q;
  logic [REG_AW-1:0] ptr_q;
  logic              ack_rise_q;
  logic              rw_q;
  logic              sda_en_q;
  logic              wr_valid_q;
  logic              busy_q;
  logic [REG_AW-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic [7:0]        regs_q [NREG];

  logic              sda_s;
  logic              scl_rise;
  logic              scl_fall;
  logic              start_det;
  logic              stop_det;
  logic [7:0]        rx_byte_d;
  logic [7:0]        rd_byte_d;
  logic [REG_AW-1:0] ptr_inc_d;

  // Index [1] is the synchronized level, [2] the previous sample for edge detection.
  assign sda_s     = sda_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_det = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[1] & sda_sync_q[2];
  assign stop_det  = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[1] & ~sda_sync_q[2];
  assign rx_byte_d = {shift_q[6:0], sda_s};
  assign rd_byte_d = regs_q[ptr_q];
  assign ptr_inc_d = ptr_q + REG_AW'(1);

  assign o_SDA_OUT  = 1'b0;
  assign o_SCL_EN   = 1'b0;
  assign o_SDA_EN   = sda_en_q;
  assign o_wr_valid = wr_valid_q;
  assign o_wr_addr  = wr_addr_q;
  assign o_wr_data  = wr_data_q;
  assign o_busy     = busy_q;

  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q    <= IDLE;
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      ack_rise_q <= 1'b0;
      rw_q       <= 1'b0;
      sda_en_q   <= 1'b0;
      wr_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      scl_sync_q <= {scl_sync_q[1:0], i_SCL_IN};
      sda_sync_q <= {sda_sync_q[1:0], i_SDA_IN};
      wr_valid_q <= 1'b0;
      // Bus commits below are scheduled later in this block, so they win a same-address race.
      if (i_host_we) regs_q[i_host_addr] <= i_host_wdata;

      if (stop_det) begin
        state_q  <= IDLE;
        sda_en_q <= 1'b0;
        busy_q   <= 1'b0;
      end else if (start_det) begin
        state_q   <= ADDR;
        bit_cnt_q <= '0;
        sda_en_q  <= 1'b0;
      end else if (scl_rise) begin
        case (state_q)
          ADDR, PTR, WDATA: begin
            shift_q   <= rx_byte_d;
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              ack_rise_q <= 1'b0;
              case (state_q)
                ADDR: begin
                  if (rx_byte_d[7:1] == DEV_ADDR) begin
                    state_q <= ADDR_ACK;
                    rw_q    <= rx_byte_d[0];
                    busy_q  <= 1'b1;
                  end else begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                  end
                end
                PTR: begin
                  ptr_q   <= rx_byte_d[REG_AW-1:0];
                  state_q <= PTR_ACK;
                end
                default: begin
                  regs_q[ptr_q] <= rx_byte_d;
                  wr_valid_q    <= 1'b1;
                  wr_addr_q     <= ptr_q;
                  wr_data_q     <= rx_byte_d;
                  ptr_q         <= ptr_inc_d;
                  state_q       <= WDATA_ACK;
                end
              endcase
            end
          end
          RDATA: begin
            bit_cnt_q <= bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) begin
              state_q    <= RDATA_ACK;
              ack_rise_q <= 1'b0;
            end
          end
          ADDR_ACK, PTR_ACK, WDATA_ACK: ack_rise_q <= 1'b1;
          RDATA_ACK: begin
            if (sda_s) begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end else begin
              ack_rise_q <= 1'b1;
              ptr_q      <= ptr_inc_d;
            end
          end
          default: ;
        endcase
      end else if (scl_fall) begin
        case (state_q)
          // First fall opens the ACK window, the fall after the 9th rise closes it.
          ADDR_ACK, PTR_ACK, WDATA_ACK: begin
            if (!ack_rise_q) begin
              sda_en_q <= 1'b1;
            end else begin
              bit_cnt_q <= '0;
              if (state_q == ADDR_ACK && rw_q) begin
                shift_q  <= rd_byte_d;
                sda_en_q <= ~rd_byte_d[7];
                state_q  <= RDATA;
              end else begin
                sda_en_q <= 1'b0;
                state_q  <= (state_q == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          RDATA: begin
            shift_q  <= {shift_q[6:0], 1'b0};
            sda_en_q <= ~shift_q[6];
          end
          RDATA_ACK: begin
            if (!ack_rise_q) begin
              sda_en_q <= 1'b0;
            end else begin
              bit_cnt_q <= '0;
              shift_q   <= rd_byte_d;
              sda_en_q  <= ~rd_byte_d[7];
              state_q   <= RDATA;
            end
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_mpr121_i2c_target.sv
// tb/tb_mpr121_i2c_target.sv - scoreboard bench acting as the I2C master for mpr121_i2c_target
// Bus writes are checked from a queue at o_wr_valid; register contents are checked by bus read-back.
module tb_mpr121_i2c_target;
  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       sda_line;
  logic       sda_out, sda_en, scl_en;
  logic       host_we = 1'b0;
  logic [6:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic       wr_valid;
  logic [6:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int          checks = 0;
  int          failures = 0;
  logic [14:0] wr_q[$];
  logic [7:0]  rd_q[$];
  logic [7:0]  got_q[$];
  logic [14:0] exp_w;
  logic        watch_en = 1'b0;
  logic        seen_en = 1'b0;

  always #5 clk = ~clk;
  assign sda_line = m_sda & ~sda_en;

  mpr121_i2c_target #(.DEV_ADDR(7'h5A), .REG_AW(7)) dut (
    .i_CLK(clk), .i_RST(rst), .i_SCL_IN(scl), .i_SDA_IN(sda_line),
    .o_SDA_OUT(sda_out), .o_SDA_EN(sda_en), .o_SCL_EN(scl_en),
    .i_host_we(host_we), .i_host_addr(host_addr), .i_host_wdata(host_wdata),
    .o_wr_valid(wr_valid), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_busy(busy)
  );

  always @(negedge clk) begin
    if (!rst && wr_valid) begin
      checks++;
      if (wr_q.size() == 0) begin
        failures++;
        $display("FAIL wr_unexpected got addr=%02h data=%02h want no write", wr_addr, wr_data);
      end else begin
        exp_w = wr_q.pop_front();
        if ({wr_addr, wr_data} !== exp_w) begin
          failures++;
          $display("FAIL wr_event got addr=%02h data=%02h want addr=%02h data=%02h",
                   wr_addr, wr_data, exp_w[14:8], exp_w[7:0]);
        end
      end
    end
    if (watch_en && sda_en) seen_en = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic bit_xfer(input logic b, output logic r);
    m_sda = b; tick(Q);
    scl = 1'b1; tick(Q);
    r = sda_line; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_start;
    m_sda = 1'b1; tick(Q);
    scl = 1'b1; tick(Q);
    m_sda = 1'b0; tick(Q);
    scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    m_sda = 1'b0; tick(Q);
    scl = 1'b1; tick(Q);
    m_sda = 1'b1; tick(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bit_xfer(d[i], r);
    bit_xfer(1'b1, r);
    acked = ~r;
  endtask

  task automatic rd_byte(input logic nack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, r);
      d[i] = r;
    end
    bit_xfer(nack, r);
  endtask

  task automatic host_write(input logic [6:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    tick(1);
    host_we = 1'b0;
  endtask

  task automatic bus_read(input logic [6:0] a, input int n);
    logic       ak;
    logic [7:0] d;
    i2c_start; wr_byte(8'hB4, ak); wr_byte({1'b0, a}, ak);
    i2c_start; wr_byte(8'hB5, ak);
    for (int k = 0; k < n; k++) begin
      rd_byte(k == n - 1, d);
      got_q.push_back(d);
    end
    i2c_stop;
  endtask

  task automatic test_reset;
    tick(2);
    checks++;
    if (sda_en !== 1'b0) begin failures++; $display("FAIL rst_sda_en_in_reset got=%b want=0", sda_en); end
    rst = 1'b0;
    tick(Q);
    checks++;
    if ({wr_valid, wr_addr, wr_data, busy} !== 17'd0) begin
      failures++; $display("FAIL rst_outputs got valid=%b addr=%02h data=%02h busy=%b want all 0", wr_valid, wr_addr, wr_data, busy);
    end
    checks++;
    if ({sda_en, sda_out, scl_en} !== 3'b000) begin
      failures++; $display("FAIL rst_pad_outputs got en=%b out=%b scl_en=%b want 000", sda_en, sda_out, scl_en);
    end
  endtask

  task automatic test_write_burst;
    logic a0, a1, a2, a3;
    logic [7:0] g, e;
    i2c_start;
    wr_byte(8'hB4, a0); wr_byte(8'h5E, a1);
    wr_q.push_back({7'h5E, 8'h0C}); wr_byte(8'h0C, a2);
    wr_q.push_back({7'h5F, 8'h3F}); wr_byte(8'h3F, a3);
    checks++;
    if ({a0, a1, a2, a3} !== 4'hF) begin failures++; $display("FAIL wb_acks got=%b want=1111", {a0, a1, a2, a3}); end
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL wb_busy_mid got=%b want=1", busy); end
    i2c_stop; tick(4);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL wb_busy_after_stop got=%b want=0", busy); end
    checks++;
    if (wr_q.size() != 0) begin failures++; $display("FAIL wb_write_count got_pending=%0d want=0", wr_q.size()); end
    rd_q.push_back(8'h0C);
    bus_read(7'h5E, 1);
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = rd_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL wb_readback got=%02h want=%02h", g, e); end
    end
  endtask

  task automatic test_read_rs;
    logic       ak;
    logic [7:0] d0, d1, e;
    host_write(7'h00, 8'hA5); host_write(7'h01, 8'h03);
    rd_q.push_back(8'hA5); rd_q.push_back(8'h03);
    i2c_start; wr_byte(8'hB4, ak); wr_byte(8'h00, ak);
    i2c_start; wr_byte(8'hB5, ak);
    checks++;
    if (ak !== 1'b1) begin failures++; $display("FAIL rd_addr_ack got=%b want=1", ak); end
    rd_byte(1'b0, d0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL rd_busy_after_ack got=%b want=1", busy); end
    rd_byte(1'b1, d1);
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL rd_busy_after_nack got=%b want=0", busy); end
    i2c_stop;
    e = rd_q.pop_front(); checks++;
    if (d0 !== e) begin failures++; $display("FAIL rd_byte0 got=%02h want=%02h", d0, e); end
    e = rd_q.pop_front(); checks++;
    if (d1 !== e) begin failures++; $display("FAIL rd_byte1 got=%02h want=%02h", d1, e); end
  endtask

  task automatic test_mismatch;
    logic ak;
    seen_en = 1'b0; watch_en = 1'b1;
    i2c_start; wr_byte(8'hB6, ak);
    checks++;
    if (ak !== 1'b0) begin failures++; $display("FAIL mm_addr_ack got=%b want=0", ak); end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL mm_busy got=%b want=0", busy); end
    wr_byte(8'h00, ak); wr_byte(8'h12, ak);
    i2c_stop;
    watch_en = 1'b0;
    checks++;
    if (seen_en !== 1'b0) begin failures++; $display("FAIL mm_sda_driven got=%b want=0", seen_en); end
  endtask

  task automatic test_wrap;
    logic       ak;
    logic [7:0] g, e;
    i2c_start; wr_byte(8'hB4, ak); wr_byte(8'h7F, ak);
    wr_q.push_back({7'h7F, 8'h11}); wr_byte(8'h11, ak);
    wr_q.push_back({7'h00, 8'h22}); wr_byte(8'h22, ak);
    i2c_stop;
    rd_q.push_back(8'h11); rd_q.push_back(8'h22);
    bus_read(7'h7F, 2);
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = rd_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL wrap_readback got=%02h want=%02h", g, e); end
    end
  endtask

  task automatic test_abort_reset;
    logic       ak, r;
    logic [7:0] g, e;
    host_write(7'h00, 8'h00);
    i2c_start; wr_byte(8'hB4, ak); wr_byte(8'h00, ak);
    i2c_start; wr_byte(8'hB5, ak);
    for (int i = 0; i < 4; i++) bit_xfer(1'b1, r);
    checks++;
    if (sda_en !== 1'b1) begin failures++; $display("FAIL ab_bit3_driven got=%b want=1", sda_en); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (sda_en !== 1'b0) begin failures++; $display("FAIL ab_sda_release got=%b want=0", sda_en); end
    checks++;
    if ({wr_valid, wr_addr, wr_data, busy} !== 17'd0) begin
      failures++; $display("FAIL ab_outputs got valid=%b addr=%02h data=%02h busy=%b want all 0", wr_valid, wr_addr, wr_data, busy);
    end
    scl = 1'b1; m_sda = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(Q);
    rd_q.push_back(8'h00);
    bus_read(7'h01, 1);
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = rd_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL ab_regs_cleared got=%02h want=%02h", g, e); end
    end
  endtask

  task automatic test_stop_mid_wdata;
    logic       ak, r;
    logic [7:0] g, e;
    i2c_start; wr_byte(8'hB4, ak); wr_byte(8'h20, ak);
    bit_xfer(1'b1, r); bit_xfer(1'b0, r); bit_xfer(1'b1, r); bit_xfer(1'b0, r);
    i2c_stop; tick(4);
    checks++;
    if ({busy, sda_en} !== 2'b00) begin failures++; $display("FAIL sm_idle got busy=%b en=%b want 0 0", busy, sda_en); end
    rd_q.push_back(8'h00);
    bus_read(7'h20, 1);
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = rd_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL sm_no_write got=%02h want=%02h", g, e); end
    end
  endtask

  task automatic test_collision;
    logic       ak;
    logic       hit;
    logic [7:0] g, e;
    hit = 1'b0;
    i2c_start; wr_byte(8'hB4, ak); wr_byte(8'h10, ak);
    wr_q.push_back({7'h10, 8'hAA});
    fork
      wr_byte(8'hAA, ak);
      begin
        host_addr = 7'h10; host_wdata = 8'h55; host_we = 1'b1;
        for (int k = 0; k < 400 && !hit; k++) begin
          @(negedge clk);
          if (wr_valid) hit = 1'b1;
        end
        host_we = 1'b0;
      end
    join
    i2c_stop;
    checks++;
    if (hit !== 1'b1) begin failures++; $display("FAIL col_commit_seen got=%b want=1", hit); end
    host_write(7'h11, 8'h66);
    rd_q.push_back(8'hAA); rd_q.push_back(8'h66);
    bus_read(7'h10, 2);
    while (got_q.size() > 0) begin
      g = got_q.pop_front(); e = rd_q.pop_front(); checks++;
      if (g !== e) begin failures++; $display("FAIL col_readback got=%02h want=%02h", g, e); end
    end
  endtask

  initial begin
    test_reset;
    test_write_burst;
    test_read_rs;
    test_mismatch;
    test_wrap;
    test_abort_reset;
    test_stop_mid_wdata;
    test_collision;
    tick(4);
    checks++;
    if (wr_q.size() != 0) begin failures++; $display("FAIL final_pending_writes got=%0d want=0", wr_q.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
